// File: rtl/conv_code_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional code (generators 111/101).
// Used by the transmit encoder and its reference encode function.
package conv_code_pkg;

    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G2 = 3'b101;

    localparam int INFO_LEN  = 5;
    localparam int TAIL_LEN  = 2;
    localparam int STEPS     = INFO_LEN + TAIL_LEN;
    localparam int FRAME_LEN = 14;

    localparam logic [3:0] CNT_LAST = 4'(FRAME_LEN - 1);

    typedef logic [INFO_LEN-1:0]  info_t;
    typedef logic [FRAME_LEN-1:0] frame_t;

endpackage

// File: rtl/conv_frame_encode.sv
// Combinational encoder: 5-bit word plus 2 zero tail bits -> 14-bit frame, trellis 00 -> 00.
// Latency: none (pure combinational). Backpressure: not applicable.
// Frame bit 2i uses G1, bit 2i+1 uses G2; word MSB is encoded first.
module conv_frame_encode
    import conv_code_pkg::*;
(
    input  info_t  word,
    output frame_t frame
);

    logic [STEPS-1:0] useq;
    assign useq = {word, {TAIL_LEN{1'b0}}};

    always_comb begin
        logic [2:0] win;  // {u, s1, s2}
        frame = '0;
        win   = '0;
        for (int i = 0; i < STEPS; i++) begin
            win[2]         = useq[STEPS-1-i];
            frame[2*i]     = ^(win & G1);
            frame[2*i+1]   = ^(win & G2);
            win            = {1'b0, win[2], win[1]};
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Serial framed convolutional encoder; optional err_mask XOR at load under CONV_ENC_ERRINJ_EN.
// Latency: accept to slot 0 of carrying frame is 1..14 cycles; continuous 14-cycle frames.
// Backpressure: one-entry buffer, data_ready low from accept until the next load edge.
module conv_frame_encoder
    import conv_code_pkg::*;
#(
    parameter info_t IDLE_PATTERN = 5'b00000
)(
    input  logic                 clk1,
    input  logic                 reset,
    input  logic [INFO_LEN-1:0]  data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 txbit,
    output logic                 frame_start,
    output logic                 frame_is_data
`ifdef CONV_ENC_ERRINJ_EN
    ,
    input  logic [FRAME_LEN-1:0] err_mask
`endif
);

    logic [3:0] cnt;
    logic       run;
    logic       buf_full;
    info_t      buf_word;
    info_t      src_word;
    frame_t     frame_sr;
    frame_t     code;
    frame_t     load_frame;
    logic       load;
    logic       accept;

    assign load       = (cnt == CNT_LAST);
    assign data_ready = run && !buf_full;
    assign accept     = data_valid && data_ready;
    assign txbit      = frame_sr[0];
    assign src_word   = buf_full ? buf_word : IDLE_PATTERN;

    conv_frame_encode u_encode (
        .word  (src_word),
        .frame (code)
    );

`ifdef CONV_ENC_ERRINJ_EN
    assign load_frame = code ^ err_mask;
`else
    assign load_frame = code;
`endif

    always_ff @(posedge clk1) begin
        if (!reset) begin
            cnt           <= CNT_LAST;
            run           <= 1'b0;
            buf_full      <= 1'b0;
            buf_word      <= '0;
            frame_sr      <= '0;
            frame_start   <= 1'b0;
            frame_is_data <= 1'b0;
        end else begin
            run         <= 1'b1;
            frame_start <= load;
            if (load) begin
                frame_sr      <= load_frame;
                cnt           <= '0;
                frame_is_data <= buf_full;
            end else begin
                frame_sr <= frame_sr >> 1;
                cnt      <= cnt + 4'd1;
            end
            // A word accepted on the load edge is held for the following frame.
            if (accept) begin
                buf_full <= 1'b1;
                buf_word <= data_in;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Randomized bench for conv_frame_encoder against a frame-level reference model.
module tb_conv_frame_encoder;

    localparam logic [4:0] IDLE = 5'b00000;

    logic        clk1 = 1'b0;
    logic        reset;
    logic [4:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        txbit;
    logic        frame_start;
    logic        frame_is_data;
    logic [13:0] err_mask;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [13:0] cur_frame;
    bit          cur_data;
    int          slot;
    bit          pend;
    logic [4:0]  pend_word;
    bit          run_m;

    always #5 clk1 = ~clk1;

    conv_frame_encoder #(.IDLE_PATTERN(IDLE)) dut (
        .clk1          (clk1),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .txbit         (txbit),
        .frame_start   (frame_start),
        .frame_is_data (frame_is_data)
`ifdef CONV_ENC_ERRINJ_EN
        ,
        .err_mask      (err_mask)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ref_enc(input logic [4:0] w);
        logic [13:0] r;
        int s1, s2, u;
        r = '0; s1 = 0; s2 = 0;
        for (int i = 0; i < 7; i++) begin
            u = (i < 5) ? ((int'(w) >> (4 - i)) & 1) : 0;
            r[2*i]   = 1'((u + s1 + s2) % 2);
            r[2*i+1] = 1'((u + s2) % 2);
            s2 = s1;
            s1 = u;
        end
        return r;
    endfunction

    function automatic logic [13:0] eff_mask(input logic [13:0] m);
`ifdef CONV_ENC_ERRINJ_EN
        return m;
`else
        return 14'h0 & m;
`endif
    endfunction

    // One bit clock: drive, advance model at the edge, check at the falling edge.
    task automatic cyc(input logic v, input logic [4:0] d, input logic rn, input logic [13:0] m);
        bit acc;
        data_valid = v; data_in = d; reset = rn; err_mask = m;
        @(posedge clk1);
        if (!rn) begin
            cur_frame = '0; cur_data = 0; slot = 13; pend = 0; pend_word = '0; run_m = 0;
        end else begin
            acc = v && run_m && !pend;
            if (slot == 13) begin
                cur_frame = ref_enc(pend ? pend_word : IDLE) ^ eff_mask(m);
                cur_data  = pend;
                pend      = 0;
                slot      = 0;
            end else begin
                slot++;
            end
            if (acc) begin
                pend = 1; pend_word = d;
            end
            run_m = 1;
        end
        @(negedge clk1);
        check("txbit", txbit, cur_frame[slot]);
        check("frame_start", frame_start, (run_m && slot == 0));
        check("frame_is_data", frame_is_data, cur_data);
        check("data_ready", data_ready, (run_m && !pend));
    endtask

    task automatic capture(input logic [13:0] m, output logic [13:0] f, output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (frame_start && frame_is_data) ok = 1;
            else cyc(0, 5'd0, 1, m);
        end
        f = '0;
        if (ok) begin
            for (int k = 0; k < 14; k++) begin
                f[k] = txbit;
                cyc(0, 5'd0, 1, m);
            end
        end
    endtask

    task automatic send_and_capture(input string tag, input logic [4:0] w, input logic [13:0] m,
                                    input logic [13:0] exp);
        logic [13:0] f;
        bit ok;
        int n;
        n = 0;
        while (!data_ready && n < 40) begin cyc(0, 5'd0, 1, m); n++; end
        cyc(1, w, 1, m);
        capture(m, f, ok);
        if (!ok) check({tag, "_timeout"}, 0, 1);
        else check(tag, f, exp);
    endtask

    initial begin
        logic [13:0] f;
        logic [4:0]  wa, wb;
        bit ok;
        int n;

        data_valid = 0; data_in = '0; reset = 0; err_mask = '0;
        cur_frame = '0; cur_data = 0; slot = 13; pend = 0; pend_word = '0; run_m = 0;
        @(negedge clk1);
        for (int i = 0; i < 3; i++) cyc(0, 5'd0, 0, 14'h0);
        // release: first edge is a load edge carrying an idle frame
        cyc(0, 5'd0, 1, 14'h0);
        check("first_load_start", frame_start, 1);
        check("first_ready", data_ready, 1);
        for (int i = 0; i < 30; i++) cyc(0, 5'd0, 1, 14'h0);

        send_and_capture("frame_10000", 5'b10000, 14'h0, 14'h0037);
        send_and_capture("frame_11111", 5'b11111, 14'h0, 14'h395B);
`ifdef CONV_ENC_ERRINJ_EN
        send_and_capture("frame_10000_err", 5'b10000, 14'h0001, 14'h0036);
`endif

        // two words with data_valid held: second taken only right after a load edge
        wa = 5'b10110; wb = 5'b01011;
        n = 0;
        while (!data_ready && n < 40) begin cyc(0, 5'd0, 1, 14'h0); n++; end
        cyc(1, wa, 1, 14'h0);
        n = 0;
        while (!data_ready && n < 40) begin cyc(1, wb, 1, 14'h0); n++; end
        check("second_after_load_slot", slot, 0);
        check("second_after_load_data", frame_is_data, 1);
        cyc(1, wb, 1, 14'h0);
        for (int k = 0; k < 13; k++) cyc(0, 5'd0, 1, 14'h0);
        check("b2b_second_start", frame_start, 1);
        check("b2b_second_data", frame_is_data, 1);

        // data_valid exactly on the load edge with the buffer empty
        n = 0;
        while (!(slot == 13 && !pend) && n < 60) begin cyc(0, 5'd0, 1, 14'h0); n++; end
        cyc(1, 5'b11001, 1, 14'h0);
        check("load_edge_accept_idle", frame_is_data, 0);
        check("load_edge_accept_start", frame_start, 1);
        capture(14'h0, f, ok);
        if (!ok) check("load_edge_word_timeout", 0, 1);
        else check("load_edge_word", f, ref_enc(5'b11001));

        // reset mid-frame with a buffered word
        n = 0;
        while (!data_ready && n < 40) begin cyc(0, 5'd0, 1, 14'h0); n++; end
        cyc(1, 5'b11111, 1, 14'h0);
        n = 0;
        while (slot != 6 && n < 40) begin cyc(0, 5'd0, 1, 14'h0); n++; end
        cyc(0, 5'd0, 0, 14'h0);
        check("midrst_txbit", txbit, 0);
        check("midrst_ready", data_ready, 0);
        cyc(0, 5'd0, 1, 14'h0);
        check("midrst_buf_empty", data_ready, 1);
        check("midrst_idle_frame", frame_is_data, 0);

        // randomized traffic, occasional resets and error masks
        for (int i = 0; i < 3000; i++) begin
            logic v, rn;
            logic [13:0] m;
            v  = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 299) != 0);
            m  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'h0;
            cyc(v, 5'($urandom), rn, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
